// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped data cache: controller states,
// load/store size codes and the default address/block geometry.
package data_cache_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned OFFSET_W = 4;
  localparam int unsigned INDEX_W  = 3;
  localparam int unsigned TAG_W    = 32 - INDEX_W - OFFSET_W;
  localparam int unsigned BLOCK_W  = 128;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_BACK,
    FETCH
  } state_e;

endpackage

// File: rtl/data_cache_ls_align.sv
// Load extraction/extension and store byte-lane merge for one 32-bit word.
module ls_align
  import data_cache_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  byte_off_i,
  input  logic [2:0]  func3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane; halfwords align down by ignoring byte_off_i[0].
  always_comb begin
    byte_sel = word_i[{byte_off_i, 3'b000} +: 8];
    half_sel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
    load_o   = word_i;
    case (func3_i)
      F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_o = {24'h0, byte_sel};
      F3_HU:   load_o = {16'h0, half_sel};
      default: load_o = word_i;
    endcase
  end

  // Merge store data into the existing word, touching only the selected lanes.
  always_comb begin
    store_o = wdata_i;
    case (func3_i)
      F3_B: begin
        store_o = word_i;
        store_o[{byte_off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      F3_H: begin
        store_o = word_i;
        store_o[{byte_off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: store_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back data cache with a three-state refill controller.
// The pipeline holds its request stable while BUSYWAIT is high, so the
// request address doubles as the victim/refill address during a miss.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int unsigned NUM_SETS    = 2 ** INDEX_W,
  parameter int unsigned BLOCK_WORDS = BLOCK_W / WORD_W
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic                                  READ,
  input  logic                                  WRITE,
  input  logic [31:0]                           ADDRESS,
  input  logic [31:0]                           WRITEDATA,
  input  logic [2:0]                            FUNC3,
  output logic [31:0]                           READDATA,
  output logic                                  BUSYWAIT,
  output logic                                  MEM_READ,
  output logic                                  MEM_WRITE,
  output logic [31-($clog2(BLOCK_WORDS)+2):0]   MEM_ADDRESS,
  output logic [BLOCK_WORDS*32-1:0]             MEM_WRITEDATA,
  input  logic [BLOCK_WORDS*32-1:0]             MEM_READDATA,
  input  logic                                  MEM_BUSYWAIT
);

  localparam int unsigned IDX_W  = $clog2(NUM_SETS);
  localparam int unsigned OFS_W  = $clog2(BLOCK_WORDS) + 2;
  localparam int unsigned WSEL_W = OFS_W - 2;
  localparam int unsigned TG_W   = 32 - IDX_W - OFS_W;
  localparam int unsigned BLK_W  = BLOCK_WORDS * 32;

  state_e                state_q, state_d;
  logic [NUM_SETS-1:0]   valid_q, valid_d;
  logic [NUM_SETS-1:0]   dirty_q, dirty_d;
  logic [TG_W-1:0]       tag_q  [NUM_SETS];
  logic [TG_W-1:0]       tag_d  [NUM_SETS];
  logic [BLK_W-1:0]      data_q [NUM_SETS];
  logic [BLK_W-1:0]      data_d [NUM_SETS];
  logic [31:0]           readdata_q, readdata_d;

  logic [IDX_W-1:0]      req_idx;
  logic [TG_W-1:0]       req_tag;
  logic [WSEL_W-1:0]     word_sel;
  logic                  hit;
  logic [31:0]           cur_word;
  logic [31:0]           load_word;
  logic [31:0]           store_word;

  logic                  busy;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [TG_W+IDX_W-1:0] mem_addr;
  logic [31:0]           rd_out;

  assign req_idx  = ADDRESS[OFS_W +: IDX_W];
  assign req_tag  = ADDRESS[31 -: TG_W];
  assign word_sel = ADDRESS[2 +: WSEL_W];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign cur_word = data_q[req_idx][{word_sel, 5'b00000} +: 32];

  ls_align u_ls_align (
    .word_i     (cur_word),
    .byte_off_i (ADDRESS[1:0]),
    .func3_i    (FUNC3),
    .wdata_i    (WRITEDATA),
    .load_o     (load_word),
    .store_o    (store_word)
  );

  // Next-state, line updates and memory handshake for the current state.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_d      = tag_q;
    data_d     = data_q;
    readdata_d = readdata_q;
    busy       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = {req_tag, req_idx};
    rd_out     = readdata_q;
    case (state_q)
      IDLE: begin
        if (READ || WRITE) begin
          if (hit) begin
            if (WRITE) begin
              data_d[req_idx][{word_sel, 5'b00000} +: 32] = store_word;
              dirty_d[req_idx] = 1'b1;
            end else begin
              rd_out     = load_word;
              readdata_d = load_word;
            end
          end else begin
            busy    = 1'b1;
            state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITE_BACK : FETCH;
          end
        end
      end
      WRITE_BACK: begin
        busy     = 1'b1;
        mem_wr   = 1'b1;
        mem_addr = {tag_q[req_idx], req_idx};
        if (!MEM_BUSYWAIT) state_d = FETCH;
      end
      FETCH: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        if (!MEM_BUSYWAIT) begin
          data_d[req_idx]  = MEM_READDATA;
          tag_d[req_idx]   = req_tag;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset silences every request/stall output immediately, not just at the edge.
  always_comb begin
    BUSYWAIT      = busy & ~RESET;
    MEM_READ      = mem_rd & ~RESET;
    MEM_WRITE     = mem_wr & ~RESET;
    MEM_ADDRESS   = mem_addr;
    MEM_WRITEDATA = data_q[req_idx];
    READDATA      = RESET ? '0 : rd_out;
  end

  // State and line storage; reset drops any in-flight transfer untouched.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      readdata_q <= readdata_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache with a simple 5-cycle memory.
module tb_data_cache;
  import data_cache_pkg::*;

  logic         clk;
  logic         rst;
  logic         read;
  logic         write;
  logic [31:0]  address;
  logic [31:0]  writedata;
  logic [2:0]   func3;
  logic [31:0]  readdata;
  logic         busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int n_assert = 0;
  int n_fail   = 0;

  data_cache #(.NUM_SETS(8), .BLOCK_WORDS(4)) dut (
    .CLK           (clk),
    .RESET         (rst),
    .READ          (read),
    .WRITE         (write),
    .ADDRESS       (address),
    .WRITEDATA     (writedata),
    .FUNC3         (func3),
    .READDATA      (readdata),
    .BUSYWAIT      (busywait),
    .MEM_READ      (mem_read),
    .MEM_WRITE     (mem_write),
    .MEM_ADDRESS   (mem_address),
    .MEM_WRITEDATA (mem_writedata),
    .MEM_READDATA  (mem_readdata),
    .MEM_BUSYWAIT  (mem_busywait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main memory: busy for 5 cycles of each request, then one ready cycle.
  int           mem_cnt = 0;
  logic [63:0]  wb_valid = '0;
  logic [127:0] wb_mem [64];

  function automatic logic [127:0] init_block(input logic [5:0] a);
    case (a)
      6'd4:    return {32'h0BADF00D, 32'h8001FFFE, 32'h7F803355, 32'hDEADBEEF};
      6'd12:   return {32'h00000000, 32'h00000000, 32'h00000000, 32'h5555AAAA};
      default: return '0;
    endcase
  endfunction

  assign mem_busywait = (mem_read | mem_write) && (mem_cnt < 5);
  assign mem_readdata = wb_valid[mem_address[5:0]] ? wb_mem[mem_address[5:0]]
                                                    : init_block(mem_address[5:0]);

  always @(posedge clk) begin
    if (!(mem_read || mem_write) || !mem_busywait) mem_cnt <= 0;
    else mem_cnt <= mem_cnt + 1;
    if (mem_write && !mem_busywait) begin
      wb_mem[mem_address[5:0]]   <= mem_writedata;
      wb_valid[mem_address[5:0]] <= 1'b1;
    end
  end

  // Bus observer.
  int           rd_pulses = 0;
  int           rd_at_last_wr = 0;
  int           both_cnt = 0;
  logic         prev_rd = 1'b0;
  logic [27:0]  last_wr_addr = '0;
  logic [127:0] last_wr_data = '0;
  logic [27:0]  last_rd_addr = '0;

  always @(negedge clk) begin
    if (mem_read && !prev_rd) rd_pulses++;
    prev_rd = mem_read;
    if (mem_read) last_rd_addr = mem_address;
    if (mem_write) begin
      last_wr_addr  = mem_address;
      last_wr_data  = mem_writedata;
      rd_at_last_wr = rd_pulses;
    end
    if (mem_read && mem_write) both_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3);
    @(posedge clk);
    #1;
    read = rd; write = wr; address = a; writedata = wd; func3 = f3;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (busywait === 1'b1 && cycles < 50) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic load_hit(input string tag, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] exp);
    drive(1'b1, 1'b0, a, 32'h0, f3);
    @(negedge clk);
    chk({tag, "_data"}, readdata, exp);
    chk({tag, "_busy"}, busywait, 1'b0);
  endtask

  task automatic store_hit(input string tag, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] f3);
    drive(1'b0, 1'b1, a, wd, f3);
    @(negedge clk);
    chk({tag, "_busy"}, busywait, 1'b0);
  endtask

  int cyc;
  int rd_before;

  initial begin
    rst = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0; func3 = F3_W;
    repeat (2) @(posedge clk);
    #1;
    read = 1'b1; address = 32'h40;
    @(negedge clk);
    chk("rst_busy", busywait, 1'b0);
    chk("rst_mrd", mem_read, 1'b0);
    chk("rst_mwr", mem_write, 1'b0);
    chk("rst_rdata", readdata, 32'h0);
    chk("rst_valid", dut.valid_q, 8'h00);
    chk("rst_state", dut.state_q, IDLE);

    // Cold load miss, clean victim: one IDLE miss cycle plus six FETCH cycles.
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_before = rd_pulses;
    wait_ready(cyc);
    chk("cold_cycles", cyc, 7);
    chk("cold_data", readdata, 32'hDEADBEEF);
    chk("cold_rd_pulses", rd_pulses - rd_before, 1);
    chk("cold_rd_addr", last_rd_addr, 28'h4);

    load_hit("lb_neg",  32'h46, F3_B,  32'hFFFFFF80);
    load_hit("lbu",     32'h46, F3_BU, 32'h00000080);
    load_hit("lb_pos",  32'h47, F3_B,  32'h0000007F);
    load_hit("lh_lo",   32'h44, F3_H,  32'h00003355);
    load_hit("lh_hi",   32'h46, F3_H,  32'h00007F80);
    load_hit("lh_neg",  32'h48, F3_H,  32'hFFFFFFFE);
    load_hit("lhu",     32'h4A, F3_HU, 32'h00008001);
    load_hit("lh_mis",  32'h4B, F3_H,  32'hFFFF8001);
    load_hit("lw_mis",  32'h4B, F3_W,  32'h8001FFFE);
    load_hit("lbu_fe",  32'h48, F3_BU, 32'h000000FE);

    // Idle bus: no stall, READDATA holds.
    drive(1'b0, 1'b0, 32'h0, 32'h0, F3_W);
    @(negedge clk);
    chk("idle_busy", busywait, 1'b0);
    chk("idle_hold", readdata, 32'h000000FE);

    store_hit("sw", 32'h40, 32'hAABBCCDD, F3_W);
    store_hit("sh", 32'h42, 32'hFFFF1234, F3_H);
    load_hit("sh_rd", 32'h40, F3_W, 32'h1234CCDD);
    chk("sh_dirty", dut.dirty_q[4], 1'b1);
    store_hit("sb", 32'h45, 32'hABCDEF99, F3_B);
    load_hit("sb_rd", 32'h44, F3_W, 32'h7F809955);
    store_hit("sh_mis", 32'h4B, 32'h00007777, F3_H);
    load_hit("sh_mis_rd", 32'h48, F3_W, 32'h7777FFFE);

    // Conflict miss on a dirty line: write-back, then refill, then hit.
    rd_before = rd_pulses;
    drive(1'b1, 1'b0, 32'hC0, 32'h0, F3_W);
    wait_ready(cyc);
    chk("wb_cycles", cyc, 13);
    chk("wb_data_rd", readdata, 32'h5555AAAA);
    chk("wb_addr", last_wr_addr, 28'h4);
    chk("wb_block", last_wr_data,
        {32'h0BADF00D, 32'h7777FFFE, 32'h7F809955, 32'h1234CCDD});
    chk("wb_before_rd", rd_at_last_wr, rd_before);
    chk("wb_rd_pulses", rd_pulses - rd_before, 1);
    chk("wb_rd_addr", last_rd_addr, 28'hC);
    chk("wb_clean", dut.dirty_q[4], 1'b0);

    // Reset during FETCH abandons the refill.
    drive(1'b1, 1'b0, 32'h40, 32'h0, F3_W);
    @(negedge clk);
    chk("pre_miss_busy", busywait, 1'b1);
    @(negedge clk);
    chk("fetch_mrd", mem_read, 1'b1);
    chk("fetch_mwr", mem_write, 1'b0);
    chk("fetch_addr", mem_address, 28'h4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_fetch_busy", busywait, 1'b0);
    chk("rst_fetch_mrd", mem_read, 1'b0);
    chk("rst_fetch_rdata", readdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; read = 1'b0;
    @(negedge clk);
    chk("post_rst_state", dut.state_q, IDLE);
    chk("post_rst_busy", busywait, 1'b0);
    chk("post_rst_mrd", mem_read, 1'b0);
    chk("post_rst_tag", dut.tag_q[4], 25'd1);
    drive(1'b1, 1'b0, 32'h40, 32'h0, F3_W);
    wait_ready(cyc);
    chk("post_rst_miss_cycles", cyc, 7);
    chk("post_rst_rd", readdata, 32'h1234CCDD);

    // READ and WRITE together on a hit: store wins, no stall.
    drive(1'b1, 1'b1, 32'h4C, 32'hCAFEF00D, F3_W);
    @(negedge clk);
    chk("rw_busy", busywait, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, F3_W);
    @(negedge clk);
    chk("rw_dirty", dut.dirty_q[4], 1'b1);
    load_hit("rw_rd", 32'h4C, F3_W, 32'hCAFEF00D);

    // Write miss to an empty set, then the store lands after refill.
    drive(1'b0, 1'b1, 32'h0, 32'h000000A5, F3_B);
    wait_ready(cyc);
    chk("wmiss_cycles", cyc, 7);
    load_hit("wmiss_lb", 32'h0, F3_B, 32'hFFFFFFA5);
    load_hit("wmiss_lw", 32'h0, F3_W, 32'h000000A5);

    chk("never_both", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
